// File: rtl/fetch_unit_param_pkg.sv
// Shared defaults, boolean constants and refill FSM encoding
// for the parametrised fetch front end.
package fetch_unit_param_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [63:0] RESET_PC_DEF = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_ABORT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_param_iqueue.sv
// fetch_iqueue: circular FIFO with push, pop, flush and count.
// Ports: push/pop/flush_i controls, push_data_i, head_data_o, count_o.
module fetch_iqueue
  import fetch_unit_param_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = nxt(tail_q);
      if (pop_i)  head_d = nxt(head_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && en_i && push_i && !flush_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit_param.sv
// fetch_unit_param: direct-mapped I-cache with burst refill FSM,
// predictor-steered PC and an instruction queue feeding dispatch.
// Ports: mem_* refill bus, pc/inst/pred_* predictor link,
// disp_* issue port, rob_* rollback and jalr release.
module fetch_unit_param
  import fetch_unit_param_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INST_W   = INST_W_DEF,
  parameter int IC_IDX_W = 9,
  parameter int IQ_DEPTH = 8,
  parameter int BURST_LEN = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              mem_avail_in,
  input  logic              mem_word_valid_in,
  input  logic [INST_W-1:0] mem_word_in,
  input  logic              mem_done_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_abort_out,
  output logic [ADDR_W-1:0] pc_to_pred,
  output logic [INST_W-1:0] inst_to_pred,
  input  logic              pred_taken_in,
  input  logic [ADDR_W-1:0] pred_offset_in,
  input  logic              pred_is_jalr_in,
  input  logic              disp_full_in,
  output logic              disp_valid_out,
  output logic [INST_W-1:0] disp_inst_out,
  output logic [ADDR_W-1:0] disp_pc_out,
  output logic              disp_pred_taken_out,
  output logic [ADDR_W-1:0] disp_fallthru_out,
  input  logic              rob_rollback_in,
  input  logic [ADDR_W-1:0] rob_target_in,
  input  logic              rob_jalr_commit_in
);

  localparam int IC_N = 1 << IC_IDX_W;
  localparam int CW   = $clog2(IQ_DEPTH) + 1;
  localparam int BCW  = $clog2(BURST_LEN + 1);
  localparam int EW   = INST_W + 2 * ADDR_W + 1;
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  // cache storage
  logic [IC_N-1:0]   ic_valid_q;
  logic [ADDR_W-1:0] ic_tag_q  [IC_N];
  logic [INST_W-1:0] ic_data_q [IC_N];

  // fetch state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              stall_q, stall_d;

  // refill FSM
  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              abort_q, abort_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BCW-1:0]    cnt_q, cnt_d;
  logic              wr_en;

  // issue registers
  logic              dv_q, dv_d;
  logic [INST_W-1:0] dinst_q, dinst_d;
  logic [ADDR_W-1:0] dpc_q, dpc_d;
  logic              dtk_q, dtk_d;
  logic [ADDR_W-1:0] dft_q, dft_d;

  logic [IC_IDX_W-1:0] rd_idx, wr_idx;
  logic [ADDR_W-1:0]   wr_addr, pc_plus4;
  logic [INST_W-1:0]   rd_inst;
  logic                hit, do_pop, do_ins;

  logic [CW-1:0]     iq_count;
  logic [EW-1:0]     iq_push_data, iq_head;
  logic [INST_W-1:0] h_inst;
  logic [ADDR_W-1:0] h_pc, h_ft;
  logic              h_tk;

  assign rd_idx   = pc_q[IC_IDX_W+1:2];
  assign hit      = ic_valid_q[rd_idx] && (ic_tag_q[rd_idx] == pc_q);
  assign rd_inst  = hit ? ic_data_q[rd_idx] : '0;
  assign pc_plus4 = pc_q + FOUR;

  assign wr_addr = base_q + (ADDR_W'(cnt_q) << 2);
  assign wr_idx  = wr_addr[IC_IDX_W+1:2];

  assign do_pop = !disp_full_in && (iq_count != '0);
  assign do_ins = hit && !stall_q &&
                  ((iq_count < CW'(IQ_DEPTH)) || do_pop);

  assign iq_push_data = {rd_inst, pc_q, pred_taken_in, pc_plus4};
  assign {h_inst, h_pc, h_tk, h_ft} = iq_head;

  fetch_iqueue #(
    .DEPTH (IQ_DEPTH),
    .W     (EW)
  ) u_iq (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .en_i        (rdy_in),
    .flush_i     (rob_rollback_in),
    .push_i      (do_ins && !rob_rollback_in),
    .push_data_i (iq_push_data),
    .pop_i       (do_pop && !rob_rollback_in),
    .head_data_o (iq_head),
    .count_o     (iq_count)
  );

  // PC steering, jalr stall and issue staging
  always_comb begin
    pc_d    = pc_q;
    stall_d = stall_q;
    dv_d    = FALSE;
    dinst_d = '0;
    dpc_d   = '0;
    dtk_d   = FALSE;
    dft_d   = '0;
    if (rob_rollback_in) begin
      pc_d    = rob_target_in;
      stall_d = FALSE;
    end else begin
      if (do_pop) begin
        dv_d    = TRUE;
        dinst_d = h_inst;
        dpc_d   = h_pc;
        dtk_d   = h_tk;
        dft_d   = h_ft;
      end
      if (do_ins) begin
        pc_d = pred_taken_in ? pc_q + pred_offset_in : pc_plus4;
      end
      // a jalr inserted alongside a commit keeps the stall
      if (do_ins && pred_is_jalr_in) begin
        stall_d = TRUE;
      end else if (rob_jalr_commit_in) begin
        stall_d = FALSE;
      end
    end
  end

  // refill FSM next-state and outputs
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    abort_d = FALSE;
    base_d  = base_q;
    cnt_d   = cnt_q;
    wr_en   = FALSE;
    unique case (state_q)
      ST_IDLE: begin
        if (!rob_rollback_in && !hit && mem_avail_in) begin
          state_d = ST_REFILL;
          req_d   = TRUE;
          addr_d  = pc_q;
          base_d  = pc_q;
          cnt_d   = '0;
        end
      end
      ST_REFILL: begin
        if (rob_rollback_in) begin
          state_d = ST_ABORT;
          req_d   = FALSE;
          addr_d  = '0;
          abort_d = TRUE;
        end else if (mem_word_valid_in) begin
          wr_en = TRUE;
          cnt_d = cnt_q + BCW'(1);
          // the burst length also closes a burst missing its done flag
          if (mem_done_in || cnt_q == BCW'(BURST_LEN - 1)) begin
            state_d = ST_IDLE;
            req_d   = FALSE;
            addr_d  = '0;
          end
        end
      end
      ST_ABORT: begin
        if (mem_avail_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      req_q   <= FALSE;
      addr_q  <= '0;
      abort_q <= FALSE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc_q    <= RESET_PC;
      stall_q <= FALSE;
      dv_q    <= FALSE;
      dinst_q <= '0;
      dpc_q   <= '0;
      dtk_q   <= FALSE;
      dft_q   <= '0;
    end else if (rdy_in) begin
      pc_q    <= pc_d;
      stall_q <= stall_d;
      dv_q    <= dv_d;
      dinst_q <= dinst_d;
      dpc_q   <= dpc_d;
      dtk_q   <= dtk_d;
      dft_q   <= dft_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ic_valid_q <= '0;
    end else if (rdy_in && wr_en) begin
      ic_valid_q[wr_idx] <= TRUE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && wr_en) begin
      ic_tag_q[wr_idx]  <= wr_addr;
      ic_data_q[wr_idx] <= mem_word_in;
    end
  end

  assign mem_req_out         = req_q;
  assign mem_addr_out        = addr_q;
  assign mem_abort_out       = abort_q;
  assign pc_to_pred          = pc_q;
  assign inst_to_pred        = rd_inst;
  assign disp_valid_out      = dv_q;
  assign disp_inst_out       = dinst_q;
  assign disp_pc_out         = dpc_q;
  assign disp_pred_taken_out = dtk_q;
  assign disp_fallthru_out   = dft_q;

endmodule

// File: tb/tb_fetch_unit_param.sv
// Randomised bench for fetch_unit_param against a queue-based
// reference model, plus directed cold-start and rollback checks.
module tb_fetch_unit_param;

  localparam int AW   = 32;
  localparam int IW   = 32;
  localparam int IXW  = 9;
  localparam int D    = 8;
  localparam int BL   = 4;
  localparam int NIDX = 1 << IXW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rdy, mem_avail, mem_wv, mem_done;
  logic [IW-1:0] mem_word;
  logic          mem_req_out, mem_abort_out;
  logic [AW-1:0] mem_addr_out, pc_to_pred;
  logic [IW-1:0] inst_to_pred;
  logic          taken, jalr, disp_full, rollback, commit;
  logic [AW-1:0] off, target;
  logic          disp_valid_out, disp_pred_taken_out;
  logic [IW-1:0] disp_inst_out;
  logic [AW-1:0] disp_pc_out, disp_fallthru_out;

  fetch_unit_param #(
    .ADDR_W(AW), .INST_W(IW), .IC_IDX_W(IXW),
    .IQ_DEPTH(D), .BURST_LEN(BL), .RESET_PC(32'h0)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst_n),
    .rdy_in              (rdy),
    .mem_avail_in        (mem_avail),
    .mem_word_valid_in   (mem_wv),
    .mem_word_in         (mem_word),
    .mem_done_in         (mem_done),
    .mem_req_out         (mem_req_out),
    .mem_addr_out        (mem_addr_out),
    .mem_abort_out       (mem_abort_out),
    .pc_to_pred          (pc_to_pred),
    .inst_to_pred        (inst_to_pred),
    .pred_taken_in       (taken),
    .pred_offset_in      (off),
    .pred_is_jalr_in     (jalr),
    .disp_full_in        (disp_full),
    .disp_valid_out      (disp_valid_out),
    .disp_inst_out       (disp_inst_out),
    .disp_pc_out         (disp_pc_out),
    .disp_pred_taken_out (disp_pred_taken_out),
    .disp_fallthru_out   (disp_fallthru_out),
    .rob_rollback_in     (rollback),
    .rob_target_in       (target),
    .rob_jalr_commit_in  (commit)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wordfn(logic [31:0] a);
    return 32'h13 + a * 32'h20;
  endfunction

  // reference model state
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] ft;
  } ent_t;
  localparam ent_t ZE = '0;

  ent_t        mq[$];
  bit          cv[NIDX];
  logic [31:0] ctag[NIDX];
  logic [31:0] cdat[NIDX];
  logic [31:0] m_pc = '0, m_addr = '0, m_base = '0;
  int          m_cnt = 0, m_mode = 0;
  bit          m_stall = 0, m_req = 0, m_abort = 0, e_dv = 0;
  ent_t        e_d = '0;

  always @(posedge clk) begin : model
    int i, j;
    bit hit, pop, ins;
    logic [31:0] pc0, a;
    if (!rst_n) begin
      for (int k = 0; k < NIDX; k++) cv[k] = 0;
      mq.delete();
      m_pc = 0; m_stall = 0; m_req = 0; m_addr = 0;
      m_abort = 0; m_mode = 0; e_dv = 0; e_d = ZE;
    end else if (rdy) begin
      pc0 = m_pc;
      i   = int'(pc0[IXW+1:2]);
      hit = cv[i] && ctag[i] == pc0;
      pop = !disp_full && mq.size() != 0;
      ins = hit && !m_stall && (mq.size() < D || pop);
      m_abort = 0;
      if (rollback) begin
        mq.delete();
        m_pc = target; m_stall = 0; e_dv = 0; e_d = ZE;
        if (m_mode == 1) begin
          m_abort = 1; m_req = 0; m_addr = 0; m_mode = 2;
        end else if (m_mode == 2 && mem_avail) begin
          m_mode = 0;
        end
      end else begin
        if (pop) begin e_d = mq.pop_front(); e_dv = 1; end
        else begin e_d = ZE; e_dv = 0; end
        if (ins) begin
          mq.push_back('{inst: cdat[i], pc: pc0, tk: taken, ft: pc0 + 4});
          m_pc = taken ? pc0 + off : pc0 + 4;
        end
        if (ins && jalr) m_stall = 1;
        else if (commit) m_stall = 0;
        case (m_mode)
          0: if (!hit && mem_avail) begin
               m_mode = 1; m_req = 1; m_addr = pc0; m_base = pc0; m_cnt = 0;
             end
          1: if (mem_wv) begin
               a = m_base + 32'(4 * m_cnt);
               j = int'(a[IXW+1:2]);
               cv[j] = 1; ctag[j] = a; cdat[j] = mem_word;
               m_cnt++;
               if (mem_done) begin m_mode = 0; m_req = 0; m_addr = 0; end
             end
          default: if (mem_avail) m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin : cmp
    int i;
    logic [31:0] ei;
    i  = int'(m_pc[IXW+1:2]);
    ei = (cv[i] && ctag[i] == m_pc) ? cdat[i] : 32'h0;
    chk("pc_to_pred", pc_to_pred, m_pc);
    chk("inst_to_pred", inst_to_pred, ei);
    chk("mem_req", mem_req_out, m_req);
    chk("mem_addr", mem_addr_out, m_addr);
    chk("mem_abort", mem_abort_out, m_abort);
    chk("disp_valid", disp_valid_out, e_dv);
    chk("disp_inst", disp_inst_out, e_d.inst);
    chk("disp_pc", disp_pc_out, e_d.pc);
    chk("disp_taken", disp_pred_taken_out, e_d.tk);
    chk("disp_fallthru", disp_fallthru_out, e_d.ft);
  end

  // memory controller stand-in
  int          wv_pct = 100;
  bit          drv_active = 0;
  int          drv_k = 0;
  logic [31:0] drv_base = '0;

  task automatic apply();
    mem_wv = 0; mem_done = 0; mem_word = '0;
    if (!m_req) drv_active = 0;
    else if (!drv_active) begin
      drv_active = 1; drv_k = 0; drv_base = m_addr;
    end
    if (drv_active && rdy && rst_n && !rollback &&
        $urandom_range(0, 99) < wv_pct) begin
      mem_wv   = 1;
      mem_word = wordfn(drv_base + 32'(4 * drv_k));
      mem_done = (drv_k == BL - 1);
      drv_k++;
      if (mem_done) drv_active = 0;
    end
  endtask

  bit          rec = 0;
  bit          prev_req = 0;
  logic [31:0] obs_pc[$], obs_inst[$], req_addrs[$];

  task automatic cyc();
    apply();
    @(negedge clk);
    if (rec && disp_valid_out) begin
      obs_pc.push_back(disp_pc_out);
      obs_inst.push_back(disp_inst_out);
    end
    if (rec && mem_req_out && !prev_req) req_addrs.push_back(mem_addr_out);
    prev_req = mem_req_out;
  endtask

  initial begin
    int n;
    rst_n = 0; rdy = 1; mem_avail = 0; taken = 0; off = '0; jalr = 0;
    disp_full = 0; rollback = 0; target = '0; commit = 0;
    mem_wv = 0; mem_done = 0; mem_word = '0;
    cyc(); cyc();
    chk("rst_pc", pc_to_pred, 32'h0);
    chk("rst_req", mem_req_out, 1'b0);
    chk("rst_dv", disp_valid_out, 1'b0);

    // cold start
    rst_n = 1; mem_avail = 1; wv_pct = 100; rec = 1;
    cyc();
    chk("cold_req", mem_req_out, 1'b1);
    chk("cold_addr", mem_addr_out, 32'h0);
    for (int k = 0; k < 24; k++) cyc();
    rec = 0;
    for (int k = 0; k < 4; k++) begin
      chk("cold_pc", (obs_pc.size() > k) ? obs_pc[k] : 32'hdead, 32'(4 * k));
      chk("cold_inst", (obs_inst.size() > k) ? obs_inst[k] : 32'hdead,
          32'h13 + 32'(k * 128));
    end
    chk("second_req", (req_addrs.size() > 1) ? req_addrs[1] : 32'hdead, 32'h10);

    // rollback mid-refill after two words
    n = 0;
    while ((m_req || drv_active) && n < 100) begin cyc(); n++; end
    wv_pct = 0;
    n = 0;
    while (!m_req && n < 100) begin cyc(); n++; end
    chk("rb_reached_refill", m_req, 1'b1);
    wv_pct = 100;
    cyc(); cyc();
    wv_pct = 0; rollback = 1; target = 32'h100;
    cyc();
    chk("rb_abort", mem_abort_out, 1'b1);
    chk("rb_req", mem_req_out, 1'b0);
    chk("rb_dv", disp_valid_out, 1'b0);
    chk("rb_pc", pc_to_pred, 32'h100);
    rollback = 0; mem_avail = 0;
    cyc();
    chk("rb_abort_once", mem_abort_out, 1'b0);
    mem_avail = 1; wv_pct = 100;
    n = 0;
    while (!mem_req_out && n < 20) begin cyc(); n++; end
    chk("rb_new_addr", mem_addr_out, 32'h100);

    // randomised run
    wv_pct = 60;
    for (int k = 0; k < 4000; k++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      rdy       = ($urandom_range(0, 9) != 0);
      mem_avail = ($urandom_range(0, 9) < 7);
      taken     = ($urandom_range(0, 4) == 0);
      off       = 32'($urandom_range(0, 31)) * 4 - 32'd64;
      jalr      = ($urandom_range(0, 19) == 0);
      commit    = ($urandom_range(0, 9) == 0);
      disp_full = ($urandom_range(0, 9) < 3);
      rollback  = ($urandom_range(0, 29) == 0);
      target    = 32'($urandom_range(0, 63)) * 4;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
